alu_issue_arbiter: RTL
======================

Name: alu_issue_arbiter

Overview:
- Shares the single execute-stage ALU between two requesters: req0 = main decode pipe, req1 = secondary issuer (address-gen / debug).
- Round-robin grant with valid/ready handshake; drives the ALU input packet.
- Tracks in-flight ops through the fixed ALU latency and routes each result back to the requester that issued it.
- Sits between the decode-side issue logic and the ALU. Shares the ALU's global stall.

Parameters:
- XLEN, 32, operand/result width
- OPW, 4, ALU opcode width (ALU_NOP encoding = 0)
- LAT, 1, ALU cycles from issue to result; legal range 1..4

Ports:
- clk  in  1  clock
- rst  in  1  reset
- stall  in  1  global pipeline stall, same signal fed to the ALU
- flush  in  1  discard all in-flight ops
- reqN_valid  in  1  request valid (N = 0,1)
- reqN_ready  out  1  request accepted this cycle
- reqN_op  in  OPW  ALU opcode
- reqN_src1  in  XLEN  operand 1
- reqN_src2  in  XLEN  operand 2
- reqN_dest  in  5  destination register
- reqN_lock  in  1  hold grant (optional feature only)
- alu_valid  out  1  issue to ALU
- alu_op  out  OPW  opcode to ALU
- alu_src1  out  XLEN  operand 1 to ALU
- alu_src2  out  XLEN  operand 2 to ALU
- alu_dest  out  5  destination register to ALU
- alu_res  in  XLEN  ALU result, valid LAT cycles after issue
- rspN_valid  out  1  result for requester N
- rspN_data  out  XLEN  result data
- rspN_dest  out  5  destination register of result

Behaviour:
- Reset: rst, synchronous, active-low; clock clk.
- On reset: last_grant = 1, so req0 wins the first contention. Tag pipe fully cleared.
- Outputs during reset and the cycle after: alu_valid = 0, ready = 0, rsp*_valid = 0.
- Grant, combinational:
  - Only one requester valid -> it is granted.
  - Both valid -> grant the one != last_grant.
  - None valid -> no grant, alu_op = ALU_NOP, alu_dest = 0.
- reqN_ready = grantN & !stall & !flush.
- Issue occurs when valid & ready. On issue:
  - alu_valid = 1 and ALU fields are driven from the granted requester.
  - last_grant updates to the issuer at the clock edge.
- last_grant does not change on stall, flush, or idle cycles.
- Tag pipe: LAT entries of {valid, owner, dest}.
  - Entry 0 loads on the issue edge; entries shift one per unstalled cycle.
  - Entry LAT-1 qualifies alu_res: rsp[owner]_valid = 1, rspN_data = alu_res, rspN_dest = entry dest.
  - Responses are combinational from the final entry.
- stall = 1: the tag pipe holds, no issue occurs, rsp outputs hold their current values (results are not consumed twice by design — consumer also stalls).
- flush = 1, highest priority:
  - All tag entries are invalidated at the edge, and rsp*_valid is forced to 0 in the same cycle.
  - No issue occurs that cycle.
  - Flush overrides stall.
- Ops are issued back-to-back at one per cycle; each requester is serviced at least every 2 cycles under contention.
- An op with dest = 0 still returns a response (rspN_dest = 0); filtering is the consumer's job.
- Simultaneous issue and retire in the same cycle is legal; the pipe shifts and loads in one edge.

Optional Feature:
- Macro: ALU_ARB_LOCK_EN.
- Enabled:
  - If the last issuer is still valid and its reqN_lock = 1, it keeps the grant regardless of round-robin.
  - Lock is released when lock = 0 or valid = 0. Round-robin then resumes from that requester as last_grant.
- Disabled: reqN_lock ports exist but are ignored; pure round-robin.

Test Plan:
- Reset, then req0 ADD 3+4 dest 5, LAT=1 -> alu_valid in cycle 1; rsp0_valid = 1, data = 7, dest = 5 in cycle 2; rsp1_valid stays 0.
- Both valid continuously for 6 cycles -> grants 0,1,0,1,0,1; every response routed to the matching owner with the correct data.
- Issue req1 SUB 10-3, then stall for 3 cycles -> no new issue, ready = 0, tag pipe held; rsp1 data = 7 delivered once stall drops.
- LAT=3: issue 3 ops, flush on the cycle after the 2nd issue -> zero responses for the flushed ops, last_grant unchanged, next issue proceeds normally.
- Idle with no requests -> alu_op = 0, alu_dest = 0, alu_valid = 0, rsp valids = 0.
- ALU_ARB_LOCK_EN: req0 lock = 1 for 4 cycles with req1 also valid -> req0 granted 4 times, then req1 granted on the next cycle; with the macro off, grants alternate instead.

Source files
------------

// File: rtl/alu_issue_arbiter.sv
// alu_issue_arbiter
// Shares the single execute-stage ALU between two requesters (req0 = main
// decode pipe, req1 = secondary issuer). Round-robin grant with a valid/ready
// handshake, a LAT-deep tag pipe that follows each op through the ALU, and
// routing of each result back to the requester that issued it.
//
// Optional feature: define ALU_ARB_LOCK_EN to let the last issuer hold the
// grant while it keeps its reqN_lock_i asserted. Without the macro the lock
// inputs are ignored and arbitration is pure round-robin.
//
// Handshake: a request is accepted in a cycle exactly when reqN_valid_i and
// reqN_ready_o are both high. Ready depends on the grant and must not be used
// to form valid. alu_valid_o is high exactly in accepted cycles, and
// rspN_valid_o is high for one unstalled cycle per retiring op. While stall_i
// is high the response outputs hold their values, because the consumer is
// stalled as well.
//
// LAT must lie in 1..4.

module alu_issue_arbiter #(
    parameter int XLEN = 32,
    parameter int OPW  = 4,
    parameter int LAT  = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall_i,
    input  logic            flush_i,
    input  logic            req0_valid_i,
    output logic            req0_ready_o,
    input  logic [OPW-1:0]  req0_op_i,
    input  logic [XLEN-1:0] req0_src1_i,
    input  logic [XLEN-1:0] req0_src2_i,
    input  logic [4:0]      req0_dest_i,
    input  logic            req0_lock_i,
    input  logic            req1_valid_i,
    output logic            req1_ready_o,
    input  logic [OPW-1:0]  req1_op_i,
    input  logic [XLEN-1:0] req1_src1_i,
    input  logic [XLEN-1:0] req1_src2_i,
    input  logic [4:0]      req1_dest_i,
    input  logic            req1_lock_i,
    output logic            alu_valid_o,
    output logic [OPW-1:0]  alu_op_o,
    output logic [XLEN-1:0] alu_src1_o,
    output logic [XLEN-1:0] alu_src2_o,
    output logic [4:0]      alu_dest_o,
    input  logic [XLEN-1:0] alu_res_i,
    output logic            rsp0_valid_o,
    output logic [XLEN-1:0] rsp0_data_o,
    output logic [4:0]      rsp0_dest_o,
    output logic            rsp1_valid_o,
    output logic [XLEN-1:0] rsp1_data_o,
    output logic [4:0]      rsp1_dest_o
);

    localparam logic [OPW-1:0] ALU_NOP = '0;

    // active_q stays low through reset and the first cycle after it, which
    // keeps every handshake and response output quiet in that window.
    logic active_q;

    // Requester that issued most recently (0 or 1); reset to 1 so req0 wins
    // the first contention.
    logic last_grant_q, last_grant_d;

    // Tag pipe: one entry per ALU cycle, entry LAT-1 lines up with alu_res_i.
    logic [LAT-1:0] tag_v_q,   tag_v_d;
    logic [LAT-1:0] tag_own_q, tag_own_d;
    logic [4:0]     tag_dest_q [LAT];
    logic [4:0]     tag_dest_d [LAT];

    logic grant0, grant1;
    logic can_issue;
    logic issue;
    logic rsp_ok;

`ifdef ALU_ARB_LOCK_EN
`else
    logic lock_unused;
    assign lock_unused = req0_lock_i ^ req1_lock_i;
`endif

    // Grant selection: single requester wins outright, contention alternates,
    // and with the lock feature the last issuer may keep the grant.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (req0_valid_i && req1_valid_i) begin
            if (last_grant_q) grant0 = 1'b1;
            else              grant1 = 1'b1;
        end else if (req0_valid_i) begin
            grant0 = 1'b1;
        end else if (req1_valid_i) begin
            grant1 = 1'b1;
        end
`ifdef ALU_ARB_LOCK_EN
        if (!last_grant_q && req0_valid_i && req0_lock_i) begin
            grant0 = 1'b1;
            grant1 = 1'b0;
        end else if (last_grant_q && req1_valid_i && req1_lock_i) begin
            grant0 = 1'b0;
            grant1 = 1'b1;
        end
`endif
    end

    assign can_issue    = active_q && !stall_i && !flush_i;
    assign req0_ready_o = grant0 && can_issue;
    assign req1_ready_o = grant1 && can_issue;
    assign issue        = req0_ready_o || req1_ready_o;
    assign alu_valid_o  = issue;

    // ALU packet mux: fields follow the granted requester, NOP when idle.
    always_comb begin
        alu_op_o   = ALU_NOP;
        alu_src1_o = '0;
        alu_src2_o = '0;
        alu_dest_o = '0;
        if (grant1) begin
            alu_op_o   = req1_op_i;
            alu_src1_o = req1_src1_i;
            alu_src2_o = req1_src2_i;
            alu_dest_o = req1_dest_i;
        end else if (grant0) begin
            alu_op_o   = req0_op_i;
            alu_src1_o = req0_src1_i;
            alu_src2_o = req0_src2_i;
            alu_dest_o = req0_dest_i;
        end
    end

    // Round-robin pointer only moves on an actual issue.
    always_comb begin
        last_grant_d = last_grant_q;
        if (issue) last_grant_d = grant1;
    end

    // Tag pipe next state: flush wipes it, stall freezes it, otherwise shift
    // by one and load entry 0 with the op issued this cycle.
    always_comb begin
        tag_v_d   = tag_v_q;
        tag_own_d = tag_own_q;
        for (int i = 0; i < LAT; i++) tag_dest_d[i] = tag_dest_q[i];
        if (flush_i) begin
            tag_v_d = '0;
        end else if (!stall_i) begin
            for (int i = LAT - 1; i > 0; i--) begin
                tag_v_d[i]    = tag_v_q[i-1];
                tag_own_d[i]  = tag_own_q[i-1];
                tag_dest_d[i] = tag_dest_q[i-1];
            end
            tag_v_d[0]    = issue;
            tag_own_d[0]  = grant1;
            tag_dest_d[0] = alu_dest_o;
        end
    end

    // Responses come straight off the final tag entry; flush masks them in
    // the same cycle.
    assign rsp_ok       = active_q && !flush_i && tag_v_q[LAT-1];
    assign rsp0_valid_o = rsp_ok && !tag_own_q[LAT-1];
    assign rsp1_valid_o = rsp_ok &&  tag_own_q[LAT-1];
    assign rsp0_data_o  = alu_res_i;
    assign rsp1_data_o  = alu_res_i;
    assign rsp0_dest_o  = tag_dest_q[LAT-1];
    assign rsp1_dest_o  = tag_dest_q[LAT-1];

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            active_q     <= 1'b0;
            last_grant_q <= 1'b1;
            tag_v_q      <= '0;
            tag_own_q    <= '0;
            for (int i = 0; i < LAT; i++) tag_dest_q[i] <= '0;
        end else begin
            active_q     <= 1'b1;
            last_grant_q <= last_grant_d;
            tag_v_q      <= tag_v_d;
            tag_own_q    <= tag_own_d;
            for (int i = 0; i < LAT; i++) tag_dest_q[i] <= tag_dest_d[i];
        end
    end

endmodule
